// File: rtl/bus_target_port.sv
// ------------------------------------------------------------------
// bus_target_port: switch-side target for a 256-byte register window
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module bus_target_port #(
  parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
  parameter logic [3:0]  RESP_TAR  = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic [31:0] addrdatain,
  input  logic [1:0]  lenin,
  input  logic        ackin,
  output logic [1:0]  reqout,
  output logic [3:0]  reqtar,
  output logic [2:0]  cmdout,
  output logic [1:0]  lenout,
  output logic [31:0] addrdataout,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  output logic [5:0]  reg_addr,
  output logic [31:0] reg_wdata,
  input  logic [31:0] reg_rdata,
  output logic        busy
);

  localparam logic [2:0]  c_ST_IDLE      = 3'd0;
  localparam logic [2:0]  c_ST_WDATA     = 3'd1;
  localparam logic [2:0]  c_ST_RD_FETCH  = 3'd2;
  localparam logic [2:0]  c_ST_RESP_REQ  = 3'd3;
  localparam logic [2:0]  c_ST_RESP_DATA = 3'd4;

  localparam logic [2:0]  c_CMD_RD       = 3'd1;
  localparam logic [2:0]  c_CMD_WR       = 3'd2;
  localparam logic [2:0]  c_RSP_RDATA    = 3'd4;
  localparam logic [2:0]  c_RSP_WACK     = 3'd5;
  localparam logic [2:0]  c_RSP_ERR      = 3'd7;
  localparam logic [31:0] c_ERR_PAYLOAD  = 32'hDEAD_BEEF;

  logic [2:0]  state_q, state_d;
  logic [5:0]  idx_q;
  logic [4:0]  cnt_q;
  logic [4:0]  beats_q;
  logic [2:0]  resp_cmd_q;
  logic [1:0]  resp_len_q;
  logic [31:0] resp_pay_q;
  logic [4:0]  resp_beats_q;
  logic [31:0] buf_q [16];

  logic        w_hit;
  logic [4:0]  w_beats;
  logic        w_wr_last;
  logic        w_rd_strobe;
  logic        w_fetch_done;
  logic        w_resp_last;
  logic [3:0]  w_cap_idx;

  assign w_hit        = (addrdatain[31:8] == BASE_ADDR[31:8]);
  assign w_wr_last    = (cnt_q == beats_q - 5'd1);
  assign w_rd_strobe  = (cnt_q < beats_q);
  assign w_fetch_done = (cnt_q == beats_q);
  assign w_resp_last  = (cnt_q == resp_beats_q - 5'd1);
  // Capture lags the strobe by one cycle, so slot = count - 1 (16 wraps to 15).
  assign w_cap_idx    = cnt_q[3:0] - 4'd1;

  always_comb begin
    w_beats = 5'd1;
    case (lenin)
      2'd0:    w_beats = 5'd1;
      2'd1:    w_beats = 5'd4;
      2'd2:    w_beats = 5'd8;
      default: w_beats = 5'd16;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (selin) begin
          if (w_hit && cmdin == c_CMD_WR)      state_d = c_ST_WDATA;
          else if (w_hit && cmdin == c_CMD_RD) state_d = c_ST_RD_FETCH;
          else                                 state_d = c_ST_RESP_REQ;
        end
      end
      c_ST_WDATA:     if (selin && w_wr_last) state_d = c_ST_RESP_REQ;
      c_ST_RD_FETCH:  if (w_fetch_done)       state_d = c_ST_RESP_REQ;
      c_ST_RESP_REQ:  if (ackin)              state_d = c_ST_RESP_DATA;
      c_ST_RESP_DATA: if (w_resp_last)        state_d = c_ST_IDLE;
      default:                                state_d = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q        <= '0;
      cnt_q        <= '0;
      beats_q      <= '0;
      resp_cmd_q   <= '0;
      resp_len_q   <= '0;
      resp_pay_q   <= '0;
      resp_beats_q <= '0;
    end else begin
      case (state_q)
        c_ST_IDLE: begin
          if (selin) begin
            idx_q   <= addrdatain[7:2];
            beats_q <= w_beats;
            cnt_q   <= '0;
            // The response descriptor is fixed at request time.
            if (w_hit && cmdin == c_CMD_RD) begin
              resp_cmd_q   <= c_RSP_RDATA;
              resp_len_q   <= lenin;
              resp_pay_q   <= '0;
              resp_beats_q <= w_beats;
            end else if (w_hit && cmdin == c_CMD_WR) begin
              resp_cmd_q   <= c_RSP_WACK;
              resp_len_q   <= lenin;
              resp_pay_q   <= addrdatain;
              resp_beats_q <= 5'd1;
            end else begin
              resp_cmd_q   <= c_RSP_ERR;
              resp_len_q   <= 2'd0;
              resp_pay_q   <= c_ERR_PAYLOAD;
              resp_beats_q <= 5'd1;
            end
          end
        end
        c_ST_WDATA: begin
          if (selin) begin
            idx_q <= idx_q + 6'd1;
            cnt_q <= w_wr_last ? 5'd0 : cnt_q + 5'd1;
          end
        end
        c_ST_RD_FETCH: begin
          if (w_rd_strobe) idx_q <= idx_q + 6'd1;
          cnt_q <= w_fetch_done ? 5'd0 : cnt_q + 5'd1;
        end
        c_ST_RESP_DATA: begin
          cnt_q <= w_resp_last ? 5'd0 : cnt_q + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == c_ST_RD_FETCH && cnt_q != 5'd0) begin
      buf_q[w_cap_idx] <= reg_rdata;
    end
  end

  always_comb begin
    reqout      = 2'b00;
    reqtar      = 4'h0;
    cmdout      = 3'd0;
    lenout      = 2'd0;
    addrdataout = 32'h0;
    reg_wr_en   = 1'b0;
    reg_rd_en   = 1'b0;
    reg_addr    = 6'd0;
    reg_wdata   = 32'h0;
    busy        = (state_q != c_ST_IDLE);
    case (state_q)
      c_ST_WDATA: begin
        if (selin) begin
          reg_wr_en = 1'b1;
          reg_addr  = idx_q;
          reg_wdata = addrdatain;
        end
      end
      c_ST_RD_FETCH: begin
        if (w_rd_strobe) begin
          reg_rd_en = 1'b1;
          reg_addr  = idx_q;
        end
      end
      c_ST_RESP_REQ: begin
        reqout = 2'b01;
        reqtar = RESP_TAR;
      end
      c_ST_RESP_DATA: begin
        reqtar      = RESP_TAR;
        cmdout      = resp_cmd_q;
        lenout      = resp_len_q;
        addrdataout = (resp_cmd_q == c_RSP_RDATA) ? buf_q[cnt_q[3:0]] : resp_pay_q;
      end
      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_target_port.sv
// ------------------------------------------------------------------
// tb_bus_target_port: directed vector bench for bus_target_port
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_bus_target_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        selin;
  logic [2:0]  cmdin;
  logic [31:0] addrdatain;
  logic [1:0]  lenin;
  logic        ackin;
  logic [1:0]  reqout;
  logic [3:0]  reqtar;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata = 32'h0;
  logic        busy;

  bus_target_port #(
    .BASE_ADDR (32'hF000_0000),
    .RESP_TAR  (4'hF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .selin       (selin),
    .cmdin       (cmdin),
    .addrdatain  (addrdatain),
    .lenin       (lenin),
    .ackin       (ackin),
    .reqout      (reqout),
    .reqtar      (reqtar),
    .cmdout      (cmdout),
    .lenout      (lenout),
    .addrdataout (addrdataout),
    .reg_wr_en   (reg_wr_en),
    .reg_rd_en   (reg_rd_en),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [1:0]  len;
    int          nwdata;
    int          ack_dly;
    bit          noise;
    logic [2:0]  exp_cmd;
    int          exp_beats;
    logic [1:0]  exp_len;
    logic [31:0] exp_pay;
    int          exp_wr;
    int          exp_rd;
    logic [5:0]  exp_idx0;
    int          exp_wait;
  } vec_t;

  vec_t vecs [8];

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int both_cnt = 0;
  logic [5:0]  wr_idx [1024];
  logic [31:0] wr_dat [1024];
  logic [5:0]  rd_idx [1024];
  logic [15:0] salt = 16'h0;

  // Register file responder: data tagged with salt and index, garbage when not strobed.
  always @(posedge clk) reg_rdata <= reg_rd_en ? {salt, 10'h0, reg_addr} : 32'h0BAD_0BAD;

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_idx[wr_cnt % 1024] = reg_addr;
      wr_dat[wr_cnt % 1024] = reg_wdata;
      wr_cnt++;
    end
    if (reg_rd_en) begin
      rd_idx[rd_cnt % 1024] = reg_addr;
      rd_cnt++;
    end
    if (reg_wr_en && reg_rd_en) both_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wdat(input int vi, input int k);
    if (vi == 0 && k == 0) return 32'h1234_5678;
    return 32'hD000_0000 + 32'(vi * 256 + k);
  endfunction

  task automatic run_txn(input int vi, input vec_t v);
    int wb, rb, t, n;
    bit held;
    logic [5:0]  ix;
    logic [31:0] exp_d;
    logic [2:0]  gc [32];
    logic [1:0]  gl [32];
    logic [31:0] gd [32];
    wb   = wr_cnt;
    rb   = rd_cnt;
    salt = 16'hA000 + 16'(vi);
    selin = 1'b1; cmdin = v.cmd; addrdatain = v.addr; lenin = v.len;
    tick;
    for (int k = 0; k < v.nwdata; k++) begin
      selin = 1'b1; addrdatain = wdat(vi, k);
      tick;
    end
    selin = 1'b0; cmdin = 3'd0; addrdatain = 32'h0; lenin = 2'd0;
    t = 0;
    while (reqout !== 2'b01 && t < 200) begin
      tick;
      t++;
    end
    chk($sformatf("v%0d_req_wait", vi), 32'(t), 32'(v.exp_wait));
    chk($sformatf("v%0d_reqtar", vi), 32'(reqtar), 32'hF);
    held = 1'b1;
    for (int d = 0; d < v.ack_dly; d++) begin
      if (v.noise) begin
        selin = 1'b1; cmdin = 3'd2; addrdatain = 32'hF000_0000; lenin = 2'd0;
      end
      tick;
      if (reqout !== 2'b01 || cmdout !== 3'd0) held = 1'b0;
    end
    if (v.ack_dly > 0) chk($sformatf("v%0d_req_held", vi), 32'(held), 32'd1);
    selin = 1'b0; cmdin = 3'd0; addrdatain = 32'h0;
    ackin = 1'b1;
    tick;
    ackin = 1'b0;
    chk($sformatf("v%0d_reqout_drop", vi), 32'(reqout), 32'd0);
    n = 0;
    while (cmdout !== 3'd0 && n < 32) begin
      gc[n] = cmdout; gl[n] = lenout; gd[n] = addrdataout;
      n++;
      tick;
    end
    chk($sformatf("v%0d_beats", vi), 32'(n), 32'(v.exp_beats));
    for (int k = 0; k < n && k < v.exp_beats; k++) begin
      ix    = v.exp_idx0 + 6'(k);
      exp_d = (v.exp_cmd == 3'd4) ? {salt, 10'h0, ix} : v.exp_pay;
      chk($sformatf("v%0d_b%0d_cmd", vi, k), 32'(gc[k]), 32'(v.exp_cmd));
      chk($sformatf("v%0d_b%0d_len", vi, k), 32'(gl[k]), 32'(v.exp_len));
      chk($sformatf("v%0d_b%0d_data", vi, k), gd[k], exp_d);
    end
    chk($sformatf("v%0d_busy_end", vi), 32'(busy), 32'd0);
    chk($sformatf("v%0d_wr_pulses", vi), 32'(wr_cnt - wb), 32'(v.exp_wr));
    for (int k = 0; k < v.exp_wr && k < wr_cnt - wb; k++) begin
      ix = v.exp_idx0 + 6'(k);
      chk($sformatf("v%0d_wr%0d_idx", vi, k), 32'(wr_idx[(wb + k) % 1024]), 32'(ix));
      chk($sformatf("v%0d_wr%0d_dat", vi, k), wr_dat[(wb + k) % 1024], wdat(vi, k));
    end
    chk($sformatf("v%0d_rd_pulses", vi), 32'(rd_cnt - rb), 32'(v.exp_rd));
    for (int k = 0; k < v.exp_rd && k < rd_cnt - rb; k++) begin
      ix = v.exp_idx0 + 6'(k);
      chk($sformatf("v%0d_rd%0d_idx", vi, k), 32'(rd_idx[(rb + k) % 1024]), 32'(ix));
    end
  endtask

  initial begin
    int wb, rb, t;
    bit stall_ok;

    //          cmd   addr           len  nw  dly noise ecmd beats elen epay           wr  rd  idx0  wait
    vecs[0] = '{3'd2, 32'hF000_0010, 2'd0, 1,  0, 1'b0, 3'd5, 1,  2'd0, 32'hF000_0010, 1,  0,  6'd4,  0};
    vecs[1] = '{3'd1, 32'hF000_00F8, 2'd3, 0, 10, 1'b1, 3'd4, 16, 2'd3, 32'h0,         0,  16, 6'd62, 17};
    vecs[2] = '{3'd1, 32'hF000_0100, 2'd0, 0,  2, 1'b0, 3'd7, 1,  2'd0, 32'hDEAD_BEEF, 0,  0,  6'd0,  0};
    vecs[3] = '{3'd2, 32'hF000_0040, 2'd2, 8,  1, 1'b0, 3'd5, 1,  2'd2, 32'hF000_0040, 8,  0,  6'd16, 0};
    vecs[4] = '{3'd1, 32'hF000_0004, 2'd1, 0,  0, 1'b0, 3'd4, 4,  2'd1, 32'h0,         0,  4,  6'd1,  5};
    vecs[5] = '{3'd3, 32'hF000_0000, 2'd2, 0,  0, 1'b0, 3'd7, 1,  2'd0, 32'hDEAD_BEEF, 0,  0,  6'd0,  0};
    vecs[6] = '{3'd1, 32'hF000_00FC, 2'd0, 0,  3, 1'b1, 3'd4, 1,  2'd0, 32'h0,         0,  1,  6'd63, 2};
    vecs[7] = '{3'd2, 32'h1000_0010, 2'd1, 0,  0, 1'b0, 3'd7, 1,  2'd0, 32'hDEAD_BEEF, 0,  0,  6'd0,  0};

    reset = 1'b0; selin = 1'b0; cmdin = 3'd0; addrdatain = 32'h0; lenin = 2'd0; ackin = 1'b0;
    repeat (3) tick;
    chk("rst_reqout", 32'(reqout), 32'd0);
    chk("rst_reqtar", 32'(reqtar), 32'd0);
    chk("rst_cmdout", 32'(cmdout), 32'd0);
    chk("rst_data",   addrdataout, 32'h0);
    chk("rst_busy",   32'(busy), 32'd0);
    reset = 1'b1;
    tick;

    // Grant outside a pending response is ignored.
    ackin = 1'b1;
    tick;
    ackin = 1'b0;
    chk("idle_ack_reqout", 32'(reqout), 32'd0);
    chk("idle_ack_busy",   32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_txn(i, vecs[i]);
      tick;
    end

    // Write burst of 4 with a 3-cycle stall between beats 2 and 3.
    wb = wr_cnt;
    stall_ok = 1'b1;
    selin = 1'b1; cmdin = 3'd2; addrdatain = 32'hF000_0020; lenin = 2'd1;
    tick;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        selin = 1'b0; addrdatain = 32'hFFFF_FFFF;
        for (int s = 0; s < 3; s++) begin
          tick;
          if (busy !== 1'b1 || reqout !== 2'b00) stall_ok = 1'b0;
        end
      end
      selin = 1'b1; addrdatain = 32'hBB00_0000 + 32'(k);
      tick;
    end
    selin = 1'b0; cmdin = 3'd0; addrdatain = 32'h0; lenin = 2'd0;
    chk("stall_hold",   32'(stall_ok), 32'd1);
    chk("stall_reqout", 32'(reqout), 32'd1);
    chk("stall_pulses", 32'(wr_cnt - wb), 32'd4);
    for (int k = 0; k < 4 && k < wr_cnt - wb; k++) begin
      chk($sformatf("stall_wr%0d_idx", k), 32'(wr_idx[(wb + k) % 1024]), 32'(8 + k));
      chk($sformatf("stall_wr%0d_dat", k), wr_dat[(wb + k) % 1024], 32'hBB00_0000 + 32'(k));
    end
    ackin = 1'b1;
    tick;
    ackin = 1'b0;
    chk("stall_ack_cmd",  32'(cmdout), 32'd5);
    chk("stall_ack_len",  32'(lenout), 32'd1);
    chk("stall_ack_data", addrdataout, 32'hF000_0020);
    tick;
    chk("stall_ack_end",  32'(cmdout), 32'd0);
    tick;

    // Reset while beat 5 of a 16-beat read is on the bus.
    salt = 16'hBEEF;
    selin = 1'b1; cmdin = 3'd1; addrdatain = 32'hF000_0080; lenin = 2'd3;
    tick;
    selin = 1'b0; cmdin = 3'd0; addrdatain = 32'h0; lenin = 2'd0;
    t = 0;
    while (reqout !== 2'b01 && t < 200) begin
      tick;
      t++;
    end
    ackin = 1'b1;
    tick;
    ackin = 1'b0;
    repeat (4) tick;
    chk("mid_beat5", addrdataout, {16'hBEEF, 10'h0, 6'd36});
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("mid_rst_reqout", 32'(reqout), 32'd0);
    chk("mid_rst_reqtar", 32'(reqtar), 32'd0);
    chk("mid_rst_cmdout", 32'(cmdout), 32'd0);
    chk("mid_rst_lenout", 32'(lenout), 32'd0);
    chk("mid_rst_data",   addrdataout, 32'h0);
    chk("mid_rst_busy",   32'(busy), 32'd0);
    wb = wr_cnt;
    rb = rd_cnt;
    repeat (4) tick;
    chk("mid_rst_quiet", 32'((wr_cnt - wb) + (rd_cnt - rb)), 32'd0);
    chk("mid_rst_cmd_q", 32'(cmdout), 32'd0);
    run_txn(8, vecs[4]);
    tick;

    chk("strobe_excl", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_target_port.md
BUS_TARGET_PORT -- requirements
Module: bus_target_port

Interface
REQ-001 Parameter BASE_ADDR, 32'hF000_0000, device window base; bits [31:8] are compared, window is 256 bytes.
REQ-002 Parameter RESP_TAR, 4'hF, reqtar value driven with every response.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk only.
REQ-005 selin  in  1  switch-side select; qualifies cmdin/addrdatain/lenin this cycle.
REQ-006 cmdin  in  3  command: 3'd1 read, 3'd2 write; other values are illegal.
REQ-007 addrdatain  in  32  address on the first select beat, write data on later beats.
REQ-008 lenin  in  2  burst length code: 0=1, 1=4, 2=8, 3=16 beats.
REQ-009 ackin  in  1  switch grant for a pending response.
REQ-010 reqout  out  2  response request to switch; 2'b01 when requesting, else 0.
REQ-011 reqtar  out  4  response target.
REQ-012 cmdout  out  3  response command: 3'd4 read data, 3'd5 write ack, 3'd7 error.
REQ-013 lenout  out  2  echoed burst length code of the response.
REQ-014 addrdataout  out  32  response beat payload.
REQ-015 reg_wr_en / reg_rd_en  out  1 each  device register-file strobes.
REQ-016 reg_addr  out  6  word index; reg_wdata  out  32.
REQ-017 reg_rdata  in  32  read data, valid exactly 1 cycle after reg_rd_en.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, WDATA, RD_FETCH, RESP_REQ, RESP_DATA.
REQ-020 IDLE, selin=1: latch cmd, len, start index = addrdatain[7:2], N = beats(lenin); on a hit (addrdatain[31:8]==BASE_ADDR[31:8]) go to WDATA for a write or RD_FETCH for a read.
REQ-021 IDLE, selin=1 with miss or illegal cmd: go to RESP_REQ with a pending error response, cmdout 3'd7, 1 beat, payload 32'hDEAD_BEEF, lenout 0.
REQ-022 WDATA: each selin=1 cycle is one data beat and SHALL pulse reg_wr_en with reg_wdata=addrdatain and the current index.
REQ-023 WDATA: selin=0 is a stall (no write, no abort).
REQ-024 WDATA: after beat N, go to RESP_REQ with response cmd 3'd5, 1 beat, payload = latched start address, lenout = latched len.
REQ-025 RD_FETCH: pulse reg_rd_en for N consecutive cycles, index incrementing.
REQ-026 RD_FETCH: capture reg_rdata one cycle after each strobe into a 16x32 buffer in order.
REQ-027 RD_FETCH: go to RESP_REQ the cycle after the last capture (N+1 cycles in RD_FETCH).
REQ-028 Word index SHALL increment modulo 64 (63 wraps to 0) for both reads and writes.
REQ-029 RESP_REQ: drive reqout=2'b01 and reqtar=RESP_TAR, held until ackin=1.
REQ-030 On the cycle ackin=1 is sampled: deassert reqout and enter RESP_DATA.
REQ-031 RESP_DATA: drive cmdout, lenout and one beat on addrdataout per cycle, consecutive, no gaps.
REQ-032 RESP_DATA beat counts: read = N beats in buffer order; write ack or error = 1 beat.
REQ-033 After the final beat: cmdout, addrdataout and lenout return to 0 next cycle, state IDLE.
REQ-034 selin=1 in RD_FETCH, RESP_REQ or RESP_DATA SHALL be ignored; no queuing.
REQ-035 ackin=1 outside RESP_REQ SHALL be ignored.
REQ-036 Outside RESP_DATA, cmdout, lenout and addrdataout SHALL be 0.
REQ-037 reg_wr_en and reg_rd_en SHALL never be high in the same cycle.

Reset
REQ-038 reset=0 at a clock edge SHALL force IDLE, clear buffer pointers and beat counters, and drive all outputs to 0 next cycle (reqtar 0), regardless of current state.
REQ-039 Any in-flight burst is discarded by reset with no response; no register access occurs until a new request.

Verification
REQ-040 Single write: selin with cmd 2, addr 0xF000_0010, len 0, then data 0x1234_5678 -> reg_wr_en at index 4; reqout 01; after ackin, one beat cmd 5, payload 0xF000_0010.
REQ-041 16-beat read: cmd 1, addr 0xF000_00F8, len 3 -> reg_rd_en indices 62,63,0..13; after ackin, 16 consecutive cmd 4 beats matching reg_rdata order.
REQ-042 Address miss: cmd 1, addr 0xF000_0100 -> no reg strobes; single error beat cmd 7, payload 0xDEAD_BEEF.
REQ-043 Write stall: len 1 write with selin low 3 cycles between beats 2 and 3 -> exactly 4 reg_wr_en pulses, then write ack.
REQ-044 Delayed grant: ackin held low 10 cycles in RESP_REQ -> reqout stays 01 throughout; data starts the cycle after ackin.
REQ-045 Reset mid-read: reset=0 during RESP_DATA beat 5 -> all outputs 0 next cycle, busy 0, next request served normally.
